// File: rtl/scanout_pkg.sv
// rtl/scanout_pkg.sv - shared mode/zoom constants and helpers for the scanout engine
package scanout_pkg;

    typedef enum logic [1:0] {
        MODE_1X  = 2'b00,
        MODE_2X  = 2'b01,
        MODE_BTN = 2'b10,
        MODE_4X  = 2'b11
    } scan_mode_e;

    localparam logic [1:0] Z1 = 2'd0;
    localparam logic [1:0] Z2 = 2'd1;
    localparam logic [1:0] Z4 = 2'd2;

    // Clocks from coordinate presentation to colour output.
    function automatic int latency(input int ram_lat);
        return 3 + ram_lat;
    endfunction

    // Button cycling order 1x -> 2x -> 4x -> 1x.
    function automatic logic [1:0] next_level(input logic [1:0] z);
        return (z == Z4) ? Z1 : z + 2'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, debouncer and press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    assign o_press = r_press;

    // Two-flop synchroniser; idles at the released (high) level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples; pulse on press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_press  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_scanout.sv
// rtl/frame_scanout.sv - framebuffer scanout with centred integer zoom and frame-boundary commit
module frame_scanout
    import scanout_pkg::*;
#(
    parameter int                 IMG_W           = 320,
    parameter int                 IMG_H           = 240,
    parameter int                 SCR_W           = 640,
    parameter int                 SCR_H           = 480,
    parameter int                 ADDR_W          = 19,
    parameter int                 COLOR_W         = 8,
    parameter int                 RAM_LAT         = 1,
    parameter logic [COLOR_W-1:0] BORDER          = '0,
    parameter int                 DEBOUNCE_CYCLES = 250000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic [9:0]         i_next_x,
    input  logic [9:0]         i_next_y,
    input  logic               i_zoom_btn,
    input  logic [1:0]         i_mode,
    output logic [ADDR_W-1:0]  o_ram_address,
    input  logic [COLOR_W-1:0] i_ram_q,
    output logic [COLOR_W-1:0] o_color_out,
    output logic [1:0]         o_zoom_level
);

    // Window origins per zoom (may be negative when the scaled image is cropped).
    localparam logic signed [11:0] OX_Z1 = 12'((SCR_W - IMG_W) >>> 1);
    localparam logic signed [11:0] OX_Z2 = 12'((SCR_W - (IMG_W << 1)) >>> 1);
    localparam logic signed [11:0] OX_Z4 = 12'((SCR_W - (IMG_W << 2)) >>> 1);
    localparam logic signed [11:0] OY_Z1 = 12'((SCR_H - IMG_H) >>> 1);
    localparam logic signed [11:0] OY_Z2 = 12'((SCR_H - (IMG_H << 1)) >>> 1);
    localparam logic signed [11:0] OY_Z4 = 12'((SCR_H - (IMG_H << 2)) >>> 1);

    logic                      w_press;
    logic [1:0]                r_btn_level;
    logic [1:0]                r_zoom;
    logic [1:0]                w_pending;
    logic [1:0]                w_z;
    logic                      w_commit;
    logic signed [11:0]        w_ox;
    logic signed [11:0]        w_oy;
    logic signed [11:0]        w_dx;
    logic signed [11:0]        w_dy;
    logic signed [11:0]        w_wlim;
    logic signed [11:0]        w_hlim;
    logic                      w_inside;
    logic [11:0]               w_ix;
    logic [11:0]               w_iy;
    logic                      r_in1;
    logic [11:0]               r_ix;
    logic [11:0]               r_iy;
    logic [RAM_LAT:0]          r_in_d;
    logic [ADDR_W-1:0]         r_addr;
    logic [COLOR_W-1:0]        r_color;

    assign o_ram_address = r_addr;
    assign o_color_out   = r_color;
    assign o_zoom_level  = r_zoom;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn_n (i_zoom_btn),
        .o_press (w_press)
    );

    // Button-cycled level advances only on accepted presses while in button mode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn_level <= Z1;
        end else if (w_press && (i_mode == MODE_BTN)) begin
            r_btn_level <= next_level(r_btn_level);
        end
    end

    // Pending level: fixed by mode, or the button-cycled level.
    always_comb begin
        w_pending = r_btn_level;
        case (scan_mode_e'(i_mode))
            MODE_1X: w_pending = Z1;
            MODE_2X: w_pending = Z2;
            MODE_4X: w_pending = Z4;
            default: w_pending = r_btn_level;
        endcase
    end

    // The (0,0) coordinate itself already maps with the newly committed level.
    assign w_commit = i_enable && (i_next_x == 10'd0) && (i_next_y == 10'd0);
    assign w_z      = w_commit ? w_pending : r_zoom;

    // Active zoom changes only at the frame boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_zoom <= Z1;
        end else if (w_commit) begin
            r_zoom <= w_pending;
        end
    end

    // Screen-to-image mapping for the look-ahead coordinate.
    always_comb begin
        w_ox   = OX_Z1;
        w_oy   = OY_Z1;
        w_wlim = 12'(IMG_W);
        w_hlim = 12'(IMG_H);
        case (w_z)
            Z2: begin
                w_ox   = OX_Z2;
                w_oy   = OY_Z2;
                w_wlim = 12'(IMG_W << 1);
                w_hlim = 12'(IMG_H << 1);
            end
            Z4: begin
                w_ox   = OX_Z4;
                w_oy   = OY_Z4;
                w_wlim = 12'(IMG_W << 2);
                w_hlim = 12'(IMG_H << 2);
            end
            default: ;
        endcase
        w_dx     = $signed({2'b00, i_next_x}) - w_ox;
        w_dy     = $signed({2'b00, i_next_y}) - w_oy;
        w_inside = ({2'b00, i_next_x} < 12'(SCR_W)) && ({2'b00, i_next_y} < 12'(SCR_H)) &&
                   !w_dx[11] && (w_dx < w_wlim) && !w_dy[11] && (w_dy < w_hlim);
        w_ix     = $unsigned(w_dx) >> w_z;
        w_iy     = $unsigned(w_dy) >> w_z;
    end

    // Stage 1: inside flag and image coordinate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in1 <= 1'b0;
            r_ix  <= '0;
            r_iy  <= '0;
        end else if (!i_enable) begin
            r_in1 <= 1'b0;
            r_ix  <= '0;
            r_iy  <= '0;
        end else begin
            r_in1 <= w_inside;
            r_ix  <= w_inside ? w_ix : 12'd0;
            r_iy  <= w_inside ? w_iy : 12'd0;
        end
    end

    // Stage 2: RAM address; inside flag delayed to line up with the RAM data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr <= '0;
            r_in_d <= '0;
        end else if (!i_enable) begin
            r_addr <= '0;
            r_in_d <= '0;
        end else begin
            r_addr <= r_in1 ? ADDR_W'(32'(r_iy) * 32'(IMG_W) + 32'(r_ix)) : '0;
            r_in_d <= {r_in_d[RAM_LAT-1:0], r_in1};
        end
    end

    // Stage 3: colour select between RAM data and border.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_color <= '0;
        end else if (!i_enable) begin
            r_color <= '0;
        end else begin
            r_color <= r_in_d[RAM_LAT] ? i_ram_q : BORDER;
        end
    end

endmodule

// File: tb/tb_frame_scanout.sv
// tb/tb_frame_scanout.sv - randomized scoreboard bench for frame_scanout at RAM latency 1 and 2
module tb_frame_scanout;
    import scanout_pkg::*;

    localparam int         IMG_W  = 320;
    localparam int         IMG_H  = 240;
    localparam int         SCR_W  = 640;
    localparam int         SCR_H  = 480;
    localparam int         ADDR_W = 19;
    localparam int         DEB    = 16;
    localparam logic [7:0] BORDER = 8'hEE;
    localparam int         NREC   = 32768;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        zoom_btn = 1'b1;
    logic [9:0]  next_x = '0;
    logic [9:0]  next_y = '0;
    logic [1:0]  mode = '0;
    logic [18:0] addr1, addr2;
    logic [7:0]  q1 = '0, q2a = '0, q2 = '0;
    logic [7:0]  color1, color2;
    logic [1:0]  zl1, zl2;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    bit r_live [NREC];
    bit r_ins  [NREC];
    int r_adr  [NREC];
    int m_z = 0;
    int m_btn = 0;

    always #5 clk = ~clk;

    frame_scanout #(.IMG_W(IMG_W), .IMG_H(IMG_H), .SCR_W(SCR_W), .SCR_H(SCR_H), .ADDR_W(ADDR_W),
                    .COLOR_W(8), .RAM_LAT(1), .BORDER(BORDER), .DEBOUNCE_CYCLES(DEB)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_next_x(next_x), .i_next_y(next_y),
        .i_zoom_btn(zoom_btn), .i_mode(mode), .o_ram_address(addr1), .i_ram_q(q1),
        .o_color_out(color1), .o_zoom_level(zl1));

    frame_scanout #(.IMG_W(IMG_W), .IMG_H(IMG_H), .SCR_W(SCR_W), .SCR_H(SCR_H), .ADDR_W(ADDR_W),
                    .COLOR_W(8), .RAM_LAT(2), .BORDER(BORDER), .DEBOUNCE_CYCLES(DEB)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_next_x(next_x), .i_next_y(next_y),
        .i_zoom_btn(zoom_btn), .i_mode(mode), .o_ram_address(addr2), .i_ram_q(q2),
        .o_color_out(color2), .o_zoom_level(zl2));

    // Framebuffer models: content is the low byte of the address.
    always @(posedge clk) begin
        q1  <= addr1[7:0];
        q2a <= addr2[7:0];
        q2  <= q2a;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int fdiv2(input int d);
        return (d >= 0) ? d / 2 : -((1 - d) / 2);
    endfunction

    function automatic void model_map(input int x, input int y, input int z,
                                      output bit ins, output int adr);
        int sc, w, h, dx, dy;
        sc  = 1 << z;
        w   = IMG_W * sc;
        h   = IMG_H * sc;
        dx  = x - fdiv2(SCR_W - w);
        dy  = y - fdiv2(SCR_H - h);
        ins = (x < SCR_W) && (y < SCR_H) && (dx >= 0) && (dx < w) && (dy >= 0) && (dy < h);
        adr = ins ? ((dy / sc) * IMG_W + dx / sc) % (1 << ADDR_W) : 0;
    endfunction

    function automatic int pending_z();
        case (mode)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return m_btn;
        endcase
    endfunction

    function automatic int exp_color(input int e, input int lat);
        int s;
        s = e - latency(lat) + 1;
        if (!r_live[e]) return 0;
        for (int k = s; k < e; k++) if (!r_live[k]) return BORDER;
        return r_ins[s] ? (r_adr[s] & 255) : BORDER;
    endfunction

    task automatic step(input int x, input int y);
        int e, adr, ea;
        bit ins, live;
        next_x = 10'(x);
        next_y = 10'(y);
        e = cyc + 1;
        if (e >= NREC) begin
            $display("FAIL record budget exhausted at cycle %0d", e);
            $fatal(1);
        end
        live = rst_n && enable;
        if (live && x == 0 && y == 0) m_z = pending_z();
        model_map(x, y, m_z, ins, adr);
        r_live[e] = live;
        r_ins[e]  = ins;
        r_adr[e]  = adr;
        @(posedge clk);
        cyc = e;
        #1;
        if (e >= 6) begin
            ea = (r_live[e] && r_live[e-1] && r_ins[e-1]) ? r_adr[e-1] : 0;
            chk("addr lat1", addr1, ea);
            chk("addr lat2", addr2, ea);
            chk("color lat1", color1, exp_color(e, 1));
            chk("color lat2", color2, exp_color(e, 2));
            chk("zoom lat1", zl1, m_z);
            chk("zoom lat2", zl2, m_z);
        end
    endtask

    task automatic rnd_step();
        int x, y;
        x = $urandom_range(0, 799);
        y = $urandom_range(0, 524);
        if (x == 0 && y == 0) x = 1;
        step(x, y);
    endtask

    task automatic press(input int low_cycles);
        zoom_btn = 1'b0;
        repeat (low_cycles) rnd_step();
        zoom_btn = 1'b1;
        repeat (40) rnd_step();
    endtask

    initial begin
        #2;
        chk("reset addr", addr1, 0);
        chk("reset color", color1, 0);
        chk("reset zoom", zl1, 0);
        repeat (3) step(1, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (6) rnd_step();

        // 1x centred
        mode = MODE_1X;
        step(0, 0);
        step(160, 120);
        step(479, 359);
        chk("1x (160,120) addr", addr1, 0);
        step(159, 120);
        chk("1x (479,359) addr", addr1, 76799);
        step(640, 0);
        step(5, 5);
        step(5, 5);
        chk("1x (159,120) border", color1, BORDER);
        step(5, 5);
        chk("1x (640,0) border", color1, BORDER);

        // 2x fills the screen
        mode = MODE_2X;
        step(0, 0);
        step(1, 1);
        chk("2x (0,0) addr", addr1, 0);
        step(2, 0);
        chk("2x (1,1) addr", addr1, 0);
        step(639, 479);
        chk("2x (2,0) addr", addr1, 1);
        step(3, 3);
        chk("2x (639,479) addr", addr1, 76799);
        for (int y = 0; y < SCR_H; y += 60) for (int x = 0; x < SCR_W; x++) step(x, y + 1);

        // 4x cropped; commit pixel uses the new level
        mode = MODE_4X;
        step(0, 0);
        step(639, 479);
        chk("4x (0,0) addr", addr1, 19280);
        step(1, 1);
        chk("4x (639,479) addr", addr1, 57519);
        for (int y = 0; y < SCR_H; y += 60) for (int x = 0; x < SCR_W; x++) step(x, y + 7);

        // enable low: idle outputs, zoom held even across (0,0)
        step(0, 0);
        enable = 1'b0;
        mode   = MODE_1X;
        repeat (3) rnd_step();
        step(0, 0);
        repeat (3) rnd_step();
        chk("enable low addr", addr2, 0);
        chk("enable low color", color2, 0);
        chk("enable low zoom", zl1, 2);
        enable = 1'b1;
        repeat (8) rnd_step();

        // button mode
        mode = MODE_BTN;
        step(0, 0);
        press(10);
        step(0, 0);
        chk("glitch ignored", zl1, 0);
        repeat (5) rnd_step();
        m_btn = 1;
        press(40);
        chk("press mid-frame holds", zl1, 0);
        step(0, 0);
        chk("press commits at frame", zl1, 1);
        m_btn = 2;
        press(40);
        step(0, 0);
        chk("second press", zl1, 2);
        m_btn = 0;
        press(40);
        step(0, 0);
        chk("third press wraps", zl1, 0);

        // asynchronous reset mid-line
        mode = MODE_2X;
        step(0, 0);
        for (int x = 100; x < 120; x++) step(x, 50);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset addr", addr1, 0);
        chk("async reset color1", color1, 0);
        chk("async reset color2", color2, 0);
        chk("async reset zoom", zl2, 0);
        m_z   = 0;
        m_btn = 0;
        repeat (3) step(200, 200);
        rst_n = 1'b1;
        for (int x = 200; x < 220; x++) step(x, 200);

        // randomized traffic across modes, enables and frame boundaries
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 99) == 0) step(0, 0);
            else rnd_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
